dense_mac: RTL and testbench

Fixed-point matrix-vector engine that computes the RNN's final dense layer, D[j] = b[j] + Σ W[j][i]·h[i], for N_OUT output neurons. It takes the hidden-state vector h from the recurrent stage and reads weights and biases from external synchronous ROMs. It then streams the N_OUT rounded, saturated Q8.8 results to the downstream classifier stage. The result vector is the dense output consumed by the rest of the accelerator.

---
 rtl/dense_mac.sv | 205 ++++++++++++++++++++
 tb/tb_dense_mac.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dense_mac.sv
// dense_mac: final dense layer of the RNN, D[j] = b[j] + sum_i W[j][i]*h[i].
// Buffers the hidden vector h, streams weights/biases from 1-cycle-latency
// synchronous ROMs, accumulates at full precision, then emits one rounded
// (half up) and saturated Q8.8 result per neuron on a valid/ready stream.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start                  begin a new vector (sampled in IDLE only)
//   busy, done             activity flag, one-cycle completion pulse
//   in_valid/in_ready      hidden-vector handshake, in_data = h[i] in order
//   w_rd/w_addr/w_data     weight ROM port, address j*N_IN+i
//   b_rd/b_addr/b_data     bias ROM port, address j
//   out_valid/out_ready    result handshake; out_data, out_idx, out_last
module dense_mac #(
    parameter int unsigned N_IN  = 64,
    parameter int unsigned N_OUT = 32,
    parameter int unsigned W     = 16,
    parameter int unsigned FRAC  = 8,
    localparam int unsigned AW   = $clog2(N_IN * N_OUT),
    localparam int unsigned JW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          w_rd,
    output logic [AW-1:0] w_addr,
    input  logic [W-1:0]  w_data,
    output logic          b_rd,
    output logic [JW-1:0] b_addr,
    input  logic [W-1:0]  b_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [JW-1:0] out_idx,
    output logic          out_last
);

    localparam int unsigned IW   = $clog2(N_IN);
    localparam int unsigned PW   = 2 * W;
    localparam int unsigned ACCW = 2 * W + $clog2(N_IN) + 1;

    localparam logic [IW-1:0]          I_LAST = IW'(N_IN - 1);
    localparam logic [JW-1:0]          J_LAST = JW'(N_OUT - 1);
    localparam logic signed [ACCW-1:0] HALF   = ACCW'(1) << (FRAC - 1);
    localparam logic signed [ACCW-1:0] SAT_HI = ACCW'(2 ** (W - 1) - 1);
    localparam logic signed [ACCW-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [IW-1:0]          i;
    logic [JW-1:0]          j;
    logic signed [W-1:0]    hbuf [N_IN];

    // Read-return pipeline: tags the ROM data arriving this cycle.
    logic                   p_vld;
    logic                   p_first;
    logic [IW-1:0]          p_idx;

    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] acc_nxt;
    logic signed [ACCW-1:0] rnd;
    logic signed [PW-1:0]   prod;
    logic [W-1:0]           res;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  if (in_valid && in_ready && i == I_LAST) state_nxt = S_MAC;
            S_MAC:   if (i == I_LAST) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_OUT;
            S_OUT: begin
                if (out_valid && out_ready) begin
                    state_nxt = (j == J_LAST) ? S_DONE : S_MAC;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Full-precision product/accumulate, then round half up and saturate.
    always_comb begin
        prod = PW'(signed'(w_data)) * PW'(hbuf[p_idx]);
        if (p_first) begin
            acc_nxt = (ACCW'(signed'(b_data)) <<< FRAC) + ACCW'(prod);
        end else begin
            acc_nxt = acc + ACCW'(prod);
        end
        rnd = (acc_nxt + HALF) >>> FRAC;
        if (rnd > SAT_HI) begin
            res = W'(SAT_HI);
        end else if (rnd < SAT_LO) begin
            res = W'(SAT_LO);
        end else begin
            res = W'(rnd);
        end
    end

    // Hidden-vector buffer; contents are don't-care until loaded.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && in_valid && in_ready) begin
            hbuf[i] <= in_data;
        end
    end

    // Counters, ROM strobes, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
            w_rd      <= 1'b0;
            b_rd      <= 1'b0;
            w_addr    <= '0;
            b_addr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            i         <= '0;
            j         <= '0;
            p_vld     <= 1'b0;
            p_first   <= 1'b0;
            p_idx     <= '0;
            acc       <= '0;
        end else begin
            busy      <= (state_nxt != S_IDLE);
            done      <= (state_nxt == S_DONE);
            in_ready  <= (state_nxt == S_LOAD);
            out_valid <= (state_nxt == S_OUT);
            w_rd      <= (state_nxt == S_MAC);
            b_rd      <= (state_nxt == S_MAC) && (state != S_MAC);

            // Weight addresses run contiguously across neurons within a vector.
            if (state_nxt == S_MAC) begin
                w_addr <= (state == S_LOAD) ? '0 : w_addr + AW'(1);
            end
            if (state_nxt == S_MAC && state != S_MAC) begin
                b_addr <= (state == S_OUT) ? j + JW'(1) : '0;
            end

            p_vld   <= w_rd;
            p_first <= b_rd;
            p_idx   <= i;
            if (p_vld) begin
                acc <= acc_nxt;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        i <= '0;
                        j <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid && in_ready) begin
                        i <= (i == I_LAST) ? '0 : i + IW'(1);
                    end
                end
                S_MAC: begin
                    i <= (i == I_LAST) ? '0 : i + IW'(1);
                end
                S_DRAIN: begin
                    out_data <= res;
                    out_idx  <= j;
                    out_last <= (j == J_LAST);
                end
                S_OUT: begin
                    if (out_valid && out_ready && j != J_LAST) begin
                        j <= j + JW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_mac.sv
// Bench for dense_mac: ROM models, directed and random vectors, backpressure,
// input stalls, ignored start pulses, mid-run reset, checked against an
// arithmetic reference of the dense layer.
module tb_dense_mac;

    localparam int N_IN    = 64;
    localparam int N_OUT   = 32;
    localparam int TIMEOUT = 12000;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        w_rd;
    logic [10:0] w_addr;
    logic [15:0] w_data;
    logic        b_rd;
    logic [4:0]  b_addr;
    logic [15:0] b_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [4:0]  out_idx;
    logic        out_last;

    logic signed [15:0] hvec [N_IN];
    logic signed [15:0] wrom [N_IN*N_OUT];
    logic signed [15:0] brom [N_OUT];

    int n_tests = 0;
    int n_fail  = 0;

    dense_mac dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .w_rd      (w_rd),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .b_rd      (b_rd),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROMs with one cycle of read latency.
    always @(posedge clk) begin
        if (w_rd) w_data <= wrom[w_addr];
        if (b_rd) b_data <= brom[b_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // D[j] in plain integer arithmetic: Q16.16 sum, round half up, saturate.
    function automatic logic [15:0] ref_out(input int j);
        longint acc;
        longint r;
        acc = longint'(brom[j]) * 256;
        for (int k = 0; k < N_IN; k++) begin
            acc += longint'(wrom[j*N_IN + k]) * longint'(hvec[k]);
        end
        r = (acc + 128) >>> 8;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    // 0: rounding, 1: saturation, 2: identity, 3: random Q8.8.
    task automatic load_pattern(input int mode);
        for (int k = 0; k < N_IN; k++) begin
            case (mode)
                0:       hvec[k] = (k == 0) ? 16'sh0001 : 16'sh0000;
                1:       hvec[k] = 16'sh7FFF;
                2:       hvec[k] = (k == 0) ? 16'sh0100 : 16'sh0000;
                default: hvec[k] = 16'($urandom_range(0, 1023)) - 16'd512;
            endcase
        end
        for (int jj = 0; jj < N_OUT; jj++) begin
            case (mode)
                0:       brom[jj] = 16'sh0000;
                1:       brom[jj] = 16'sh7FFF;
                2:       brom[jj] = 16'(jj * 16);
                default: brom[jj] = 16'($urandom);
            endcase
            for (int k = 0; k < N_IN; k++) begin
                case (mode)
                    0:       wrom[jj*N_IN + k] = (k != 0) ? 16'sh0000 :
                                                 ((jj % 2 == 0) ? 16'sh0080 : 16'shFF80);
                    1:       wrom[jj*N_IN + k] = (jj < 16) ? 16'sh7FFF : 16'sh8000;
                    2:       wrom[jj*N_IN + k] = (k == 0) ? 16'sh0100 : 16'sh0000;
                    default: wrom[jj*N_IN + k] = 16'($urandom_range(0, 1023)) - 16'd512;
                endcase
            end
        end
    endtask

    // Drive one vector through the DUT and check the result stream.
    // gap_at: h index where in_valid drops for 3 cycles (-1 none)
    // bp_j:   neuron held with out_ready=0 for 5 cycles (-1 none)
    // abort_j: neuron whose MAC is cut by reset (-1 none)
    task automatic run_vector(input int gap_at, input int bp_j, input int abort_j,
                              input bit rand_ready, input bit check_time, input bit poke_start);
        int hi, jx, cyc, rd_w, rd_b, gap_n, bp_n;
        bit fin;
        logic [15:0] exp_d [N_OUT];
        for (int jj = 0; jj < N_OUT; jj++) exp_d[jj] = ref_out(jj);
        hi = 0; jx = 0; cyc = 0; rd_w = 0; rd_b = 0; gap_n = 0; bp_n = 0; fin = 1'b0;

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("in_ready_after_start", 32'(in_ready), 32'd1);

        while (!fin && cyc < TIMEOUT) begin
            if (w_rd) rd_w++;
            if (b_rd) rd_b++;
            start = (poke_start && (cyc == 10 || cyc == 200)) ? 1'b1 : 1'b0;

            in_valid = 1'b0;
            if (in_ready && hi < N_IN) begin
                if (hi == gap_at && gap_n < 3) begin
                    gap_n++;
                end else begin
                    in_valid = 1'b1;
                    in_data  = hvec[hi];
                    hi++;
                end
            end

            out_ready = 1'b0;
            if (out_valid) begin
                if (jx < N_OUT) begin
                    check("out_data", 32'(out_data), 32'(exp_d[jx]));
                    check("out_idx", 32'(out_idx), 32'(jx));
                    check("out_last", 32'(out_last), 32'(jx == N_OUT - 1));
                end else begin
                    check("extra_out_valid", 32'(out_valid), 32'd0);
                end
                if (jx == bp_j && bp_n < 5) begin
                    bp_n++;
                end else if (!rand_ready || $urandom_range(0, 3) != 0) begin
                    out_ready = 1'b1;
                    jx++;
                end
            end

            if (done) begin
                check("outputs_at_done", 32'(jx), 32'(N_OUT));
                check("weight_reads", 32'(rd_w), 32'(N_IN * N_OUT));
                check("bias_reads", 32'(rd_b), 32'(N_OUT));
                if (check_time) check("cycles_to_done", 32'(cyc), 32'(N_IN + N_OUT * (N_IN + 2)));
                fin = 1'b1;
            end

            if (abort_j >= 0 && jx == abort_j && w_rd && !b_rd) begin
                reset = 1'b1;
                start = 1'b0;
                in_valid = 1'b0;
                out_ready = 1'b0;
                @(posedge clk); #1;
                reset = 1'b0;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_out_valid", 32'(out_valid), 32'd0);
                check("abort_w_rd", 32'(w_rd), 32'd0);
                return;
            end

            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        start     = 1'b0;
        check("done_seen", 32'(fin), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_w_rd", 32'(w_rd), 32'd0);
        check("rst_b_rd", 32'(b_rd), 32'd0);
        check("rst_w_addr", 32'(w_addr), 32'd0);
        check("rst_b_addr", 32'(b_addr), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        load_pattern(0); run_vector(-1, -1, -1, 1'b0, 1'b1, 1'b0);
        load_pattern(1); run_vector(-1, -1, -1, 1'b1, 1'b0, 1'b0);
        load_pattern(2); run_vector(-1, -1, -1, 1'b0, 1'b1, 1'b0);
        load_pattern(3); run_vector(20, 3, -1, 1'b1, 1'b0, 1'b1);
        load_pattern(3); run_vector(-1, -1, 10, 1'b1, 1'b0, 1'b0);
        run_vector(-1, -1, -1, 1'b1, 1'b0, 1'b0);
        load_pattern(3); run_vector(37, 5, -1, 1'b1, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
